// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Produces the instruction fetch address for the single-cycle CPU.
//   It steps through addresses in order and takes absolute jumps and relative
//   branches from the execute side. It also handles a stall handshake, a halt
//   request and an optional limit on the number of accepted instructions.
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   pc, pc_valid      fetch address and its valid flag (registered)
//   pc_ready, stall   consumer accept and hold; stall blocks acceptance
//   redirect_valid/_target   absolute jump
//   branch_taken/_off        relative branch, signed, in PC_STEP units
//   halt_req, halted  stop request and HALT state indicator (registered)
//   instr_count       number of accepted pcs since reset (wraps)
module fetch_sequencer #(
  parameter int                PC_W      = 32,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter int                PC_STEP   = 1,
  parameter int unsigned       MAX_INSTR = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            branch_taken,
  input  logic [15:0]     branch_off,
  input  logic            halt_req,
  output logic            halted,
  output logic [31:0]     instr_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [PC_W-1:0] STEP  = PC_W'(PC_STEP);
  localparam logic [31:0]     LIMIT = 32'(MAX_INSTR);

  state_t          state;
  logic            accept;
  logic [31:0]     cnt_inc;
  logic            limit_hit;
  logic [PC_W-1:0] br_sext;
  logic [PC_W-1:0] br_tgt;

  // pc_valid is high only in RUN, so accept cannot happen in BOOT or HALT.
  assign accept    = pc_valid & pc_ready & ~stall;
  assign cnt_inc   = instr_count + 32'd1;
  assign limit_hit = (LIMIT != 32'd0) && accept && (cnt_inc == LIMIT);
  assign br_sext   = PC_W'($signed(branch_off));
  // Multiply and add are both taken modulo 2^PC_W, so a wrap past the
  // address space is silent.
  assign br_tgt    = pc + br_sext * STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pc_valid    <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state    <= RUN;
            pc_valid <= 1'b1;
          end
        end
        RUN: begin
          if (accept) instr_count <= cnt_inc;
          // Halt and the limit both freeze pc. A redirect or branch in the
          // same cycle is dropped.
          if (halt_req || limit_hit) begin
            state    <= HALT;
            pc_valid <= 1'b0;
            halted   <= 1'b1;
          end else if (redirect_valid) begin
            pc <= redirect_target;
          end else if (branch_taken) begin
            pc <= br_tgt;
          end else if (accept) begin
            pc <= pc + STEP;
          end
        end
        default: begin
          // HALT: every input is ignored until reset.
          state    <= HALT;
          pc_valid <= 1'b0;
          halted   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n, rst_n_l;
  logic        pc_ready, pc_ready_l, stall, redirect_valid, branch_taken, halt_req;
  logic [31:0] redirect_target;
  logic [15:0] branch_off;
  logic [31:0] pc, pc_l, instr_count, cnt_l;
  logic        pc_valid, halted, v_l, h_l;
  logic        zero1;
  logic [31:0] zero32;
  logic [15:0] zero16;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .branch_taken(branch_taken), .branch_off(branch_off), .halt_req(halt_req),
    .halted(halted), .instr_count(instr_count)
  );

  fetch_sequencer #(.MAX_INSTR(10)) dut_lim (
    .clk(clk), .rst_n(rst_n_l), .pc(pc_l), .pc_valid(v_l), .pc_ready(pc_ready_l),
    .stall(zero1), .redirect_valid(zero1), .redirect_target(zero32),
    .branch_taken(zero1), .branch_off(zero16), .halt_req(zero1),
    .halted(h_l), .instr_count(cnt_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] opc, input logic ov, input logic oh,
                     input logic [31:0] ocnt, input logic [31:0] epc, input logic ev,
                     input logic eh, input logic [31:0] ecnt);
    n_assert++;
    assert ({opc, ov, oh, ocnt} === {epc, ev, eh, ecnt})
    else begin
      n_fail++;
      $error("FAIL %s: got pc=%h v=%b h=%b cnt=%0d, expected pc=%h v=%b h=%b cnt=%0d",
             tag, opc, ov, oh, ocnt, epc, ev, eh, ecnt);
    end
  endtask

  initial begin
    zero1 = 1'b0; zero32 = '0; zero16 = '0;
    rst_n = 1'b0; rst_n_l = 1'b0;
    pc_ready = 1'b1; pc_ready_l = 1'b1; stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    branch_taken = 1'b0; branch_off = '0; halt_req = 1'b0;

    // 1: reset and sequential fetch
    #12;
    chk("reset", pc, pc_valid, halted, instr_count, 32'h0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("boot", pc, pc_valid, halted, instr_count, 32'h0, 1'b0, 1'b0, 32'd0);
    tick();
    chk("run_first", pc, pc_valid, halted, instr_count, 32'h0, 1'b1, 1'b0, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("seq", pc, pc_valid, halted, instr_count, 32'(k), 1'b1, 1'b0, 32'(k));
    end

    // 2: stall at pc=5
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold", pc, pc_valid, halted, instr_count, 32'h5, 1'b1, 1'b0, 32'd5);
    end
    stall = 1'b0;
    tick();
    chk("stall_release", pc, pc_valid, halted, instr_count, 32'h6, 1'b1, 1'b0, 32'd6);
    tick();
    tick();
    chk("to_pc8", pc, pc_valid, halted, instr_count, 32'h8, 1'b1, 1'b0, 32'd8);

    // 3: branch -3 from 8, then redirect beats branch
    pc_ready = 1'b0;
    branch_taken = 1'b1; branch_off = 16'hFFFD;
    tick();
    chk("branch_neg", pc, pc_valid, halted, instr_count, 32'h5, 1'b1, 1'b0, 32'd8);
    branch_taken = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h8;
    tick();
    chk("redir_back", pc, pc_valid, halted, instr_count, 32'h8, 1'b1, 1'b0, 32'd8);
    branch_taken = 1'b1; redirect_target = 32'h40;
    tick();
    chk("redir_prio", pc, pc_valid, halted, instr_count, 32'h40, 1'b1, 1'b0, 32'd8);

    // 4: redirect with pc_ready=0, then branch under stall
    branch_taken = 1'b0; redirect_target = 32'h20;
    tick();
    chk("redir_noready", pc, pc_valid, halted, instr_count, 32'h20, 1'b1, 1'b0, 32'd8);
    redirect_valid = 1'b0; pc_ready = 1'b1; stall = 1'b1;
    branch_taken = 1'b1; branch_off = 16'd5;
    tick();
    chk("branch_stall", pc, pc_valid, halted, instr_count, 32'h25, 1'b1, 1'b0, 32'd8);
    branch_taken = 1'b0; stall = 1'b0;
    tick();
    chk("accept_after", pc, pc_valid, halted, instr_count, 32'h26, 1'b1, 1'b0, 32'd9);

    // address wrap in both directions
    pc_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
    tick();
    chk("redir_max", pc, pc_valid, halted, instr_count, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd9);
    redirect_valid = 1'b0; pc_ready = 1'b1;
    tick();
    chk("wrap_up", pc, pc_valid, halted, instr_count, 32'h0, 1'b1, 1'b0, 32'd10);
    pc_ready = 1'b0; branch_taken = 1'b1; branch_off = 16'hFFFF;
    tick();
    chk("wrap_down", pc, pc_valid, halted, instr_count, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd10);

    // 6: halt with accept and redirect in the same cycle
    branch_taken = 1'b0; pc_ready = 1'b1; halt_req = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h100;
    tick();
    chk("halt_enter", pc, pc_valid, halted, instr_count, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd11);
    halt_req = 1'b0; redirect_target = 32'h55;
    tick();
    chk("halt_frozen", pc, pc_valid, halted, instr_count, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd11);
    redirect_valid = 1'b0;
    tick();
    chk("halt_frozen2", pc, pc_valid, halted, instr_count, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd11);
    // asynchronous reset held for half a cycle between edges
    rst_n = 1'b0;
    #1;
    chk("async_reset", pc, pc_valid, halted, instr_count, 32'h0, 1'b0, 1'b0, 32'd0);
    #3;
    rst_n = 1'b1;
    #2;
    chk("boot_again", pc, pc_valid, halted, instr_count, 32'h0, 1'b0, 1'b0, 32'd0);
    tick();
    chk("run_again", pc, pc_valid, halted, instr_count, 32'h0, 1'b1, 1'b0, 32'd0);
    tick();
    chk("run_again2", pc, pc_valid, halted, instr_count, 32'h1, 1'b1, 1'b0, 32'd1);

    // halt_req during BOOT: no pc is ever valid
    rst_n = 1'b0; halt_req = 1'b1;
    #3;
    rst_n = 1'b1;
    tick();
    chk("boot_halt", pc, pc_valid, halted, instr_count, 32'h0, 1'b0, 1'b1, 32'd0);
    halt_req = 1'b0;
    tick();
    chk("boot_halt2", pc, pc_valid, halted, instr_count, 32'h0, 1'b0, 1'b1, 32'd0);

    // 5: MAX_INSTR=10 instance
    chk("lim_reset", pc_l, v_l, h_l, cnt_l, 32'h0, 1'b0, 1'b0, 32'd0);
    rst_n_l = 1'b1;
    tick();
    chk("lim_run", pc_l, v_l, h_l, cnt_l, 32'h0, 1'b1, 1'b0, 32'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("lim_seq", pc_l, v_l, h_l, cnt_l, 32'(k), 1'b1, 1'b0, 32'(k));
    end
    tick();
    chk("lim_halt", pc_l, v_l, h_l, cnt_l, 32'h9, 1'b0, 1'b1, 32'd10);
    tick();
    chk("lim_frozen", pc_l, v_l, h_l, cnt_l, 32'h9, 1'b0, 1'b1, 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
